cnt_timer_arbiter: RTL and testbench

//  Shares one CW-bit up-counter between NREQ requesters, each asking for a timed interval of N clk cycles.

---
 rtl/cnt_timer_arbiter_pkg.sv | 13 +
 rtl/cnt_timer_arbiter_if.sv | 15 +
 rtl/cnt_timer_arbiter_cnt_core.sv | 20 ++
 rtl/cnt_timer_arbiter.sv | 114 +++++++++++
 tb/tb_cnt_timer_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cnt_timer_arbiter_pkg.sv
// Shared types and defaults for the round-robin counter/timer arbiter.
package cnt_timer_arbiter_pkg;

    localparam int unsigned NREQ_DEFAULT = 4;
    localparam int unsigned CW_DEFAULT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cnt_timer_arbiter_if.sv
// Request/grant bundle between the requesting control FSMs and the timer arbiter.
interface cnt_timer_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] req_len;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [CW-1:0]      cnt;

    modport master (output req, req_len, input gnt, done, busy, cnt);
    modport slave  (input req, req_len, output gnt, done, busy, cnt);
endinterface

// File: rtl/cnt_timer_arbiter_cnt_core.sv
// Plain CW-bit up-counter; clear has priority over enable, wraps mod 2^CW.
module cnt_core #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cnt_timer_arbiter.sv
// Round-robin arbiter sharing one up-counter between NREQ interval requesters.
module cnt_timer_arbiter
    import cnt_timer_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned CW   = CW_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    cnt_timer_arbiter_if.slave bus
);

    localparam int unsigned     IW      = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONEHOT0 = NREQ'(1);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            found;
    logic [CW-1:0]   len_m1;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic            busy_q;
    logic            abort;
    logic            term;
    logic            cnt_clr;
    logic            cnt_en;

    // First requester strictly after ptr, wrapping, so the last one served goes last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(ptr) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign abort   = (state == ST_RUN) && !bus.req[idx];
    assign term    = (state == ST_RUN) && (cnt_q == len_m1);
    assign cnt_clr = (state != ST_RUN) || abort || term;
    assign cnt_en  = (state == ST_RUN);

    cnt_core #(.CW(CW)) u_cnt_core (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            ptr    <= IW'(NREQ - 1);
            idx    <= '0;
            len_m1 <= '0;
            gnt_q  <= '0;
            done_q <= '0;
            busy_q <= 1'b0;
        end else begin
            done_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        idx    <= pick;
                        ptr    <= pick;
                        // Length 0 wraps to all-ones: a full 2^CW-cycle interval.
                        len_m1 <= bus.req_len[pick*CW +: CW] - CW'(1);
                        gnt_q  <= ONEHOT0 << pick;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (term) begin
                        gnt_q  <= '0;
                        done_q <= ONEHOT0 << idx;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.cnt  = cnt_q;

endmodule

// File: tb/tb_cnt_timer_arbiter.sv
// Self-checking bench: per-cycle expected outputs are queued at stimulus time and popped after each clock edge.
module tb_cnt_timer_arbiter;

    logic clk;
    logic rst;

    cnt_timer_arbiter_if #(.NREQ(4), .CW(8)) bus ();

    cnt_timer_arbiter #(.NREQ(4), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] done;
        logic       busy;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] lens;
        int          exp_idx;
        int          exp_len;
    } vec_t;

    exp_t  sb[$];
    int    n_chk;
    int    n_err;
    string tag;
    vec_t  vecs[7];

    task automatic push_idle();
        sb.push_back('0);
    endtask

    task automatic push_service(input int idx, input int len);
        exp_t e;
        for (int c = 0; c < len; c++) begin
            e.gnt  = 4'b0001 << idx;
            e.done = 4'b0000;
            e.busy = 1'b1;
            e.cnt  = 8'(c);
            sb.push_back(e);
        end
        e.gnt  = 4'b0000;
        e.done = 4'b0001 << idx;
        e.busy = 1'b1;
        e.cnt  = 8'd0;
        sb.push_back(e);
    endtask

    task automatic check_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL %s underflow: DUT gnt=%b done=%b busy=%b cnt=%0d but no expected entry",
                         tag, bus.gnt, bus.done, bus.busy, bus.cnt);
            end else begin
                e = sb.pop_front();
                if ({bus.gnt, bus.done, bus.busy, bus.cnt} !== e) begin
                    n_err++;
                    $display("FAIL %s: got gnt=%b done=%b busy=%b cnt=%0d, expected gnt=%b done=%b busy=%b cnt=%0d",
                             tag, bus.gnt, bus.done, bus.busy, bus.cnt, e.gnt, e.done, e.busy, e.cnt);
                end
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;

        // {len3,len2,len1,len0}; expected index follows from ptr left by the previous vector
        vecs[0] = '{4'b0001, {8'd0,   8'd0, 8'd0, 8'd5}, 0, 5};
        vecs[1] = '{4'b0110, {8'd0,   8'd7, 8'd3, 8'd0}, 1, 3};
        vecs[2] = '{4'b0011, {8'd0,   8'd0, 8'd4, 8'd2}, 0, 2};
        vecs[3] = '{4'b1001, {8'd1,   8'd0, 8'd0, 8'd9}, 3, 1};
        vecs[4] = '{4'b1000, {8'd4,   8'd0, 8'd0, 8'd0}, 3, 4};
        vecs[5] = '{4'b0101, {8'd0,   8'd3, 8'd0, 8'd6}, 0, 6};
        vecs[6] = '{4'b1100, {8'd2, 8'd255, 8'd0, 8'd0}, 2, 255};

        // Reset held with all requests asserted
        tag = "reset";
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.req_len = {4{8'd3}};
        repeat (3) push_idle();
        check_cycles(3);
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b0000;
        push_idle();
        check_cycles(1);

        // Table of single services; req_len scrambled after grant must not matter
        for (int v = 0; v < 7; v++) begin
            tag = $sformatf("vec%0d", v);
            @(negedge clk);
            bus.req = vecs[v].req;
            bus.req_len = vecs[v].lens;
            push_service(vecs[v].exp_idx, vecs[v].exp_len);
            push_idle();
            check_cycles(1);
            @(negedge clk);
            bus.req_len = $urandom;
            check_cycles(vecs[v].exp_len);
            @(negedge clk);
            bus.req = 4'b0000;
            check_cycles(1);
        end

        // Zero length means a full 256-cycle interval
        tag = "zero_len";
        @(negedge clk);
        bus.req = 4'b0100;
        bus.req_len = {8'd9, 8'd0, 8'd9, 8'd9};
        push_service(2, 256);
        push_idle();
        check_cycles(257);
        @(negedge clk);
        bus.req = 4'b0000;
        check_cycles(1);

        // Abort after three RUN cycles, then 0 and 2 pending: 2 wins with ptr=1
        tag = "abort";
        @(negedge clk);
        bus.req = 4'b0010;
        bus.req_len = {8'd0, 8'd3, 8'd10, 8'd4};
        for (int c = 0; c < 3; c++) sb.push_back('{4'b0010, 4'b0000, 1'b1, 8'(c)});
        check_cycles(3);
        @(negedge clk);
        bus.req = 4'b0101;
        push_idle();
        check_cycles(1);
        tag = "after_abort";
        push_service(2, 3);
        push_idle();
        check_cycles(4);
        @(negedge clk);
        bus.req = 4'b0000;
        check_cycles(1);

        // Reset mid-RUN at cnt=7, then regrant from scratch
        tag = "rst_mid_run";
        @(negedge clk);
        bus.req = 4'b1000;
        bus.req_len = {8'd20, 8'd0, 8'd0, 8'd0};
        for (int c = 0; c < 8; c++) sb.push_back('{4'b1000, 4'b0000, 1'b1, 8'(c)});
        check_cycles(8);
        @(negedge clk);
        rst = 1'b1;
        push_idle();
        check_cycles(1);
        @(negedge clk);
        rst = 1'b0;
        tag = "after_rst";
        push_service(3, 20);
        push_idle();
        check_cycles(21);
        @(negedge clk);
        bus.req = 4'b0000;
        check_cycles(1);

        // Round-robin from reset pointer: order 0,1,2,3,0 with one IDLE cycle between
        tag = "rr_reset";
        @(negedge clk);
        rst = 1'b1;
        push_idle();
        check_cycles(1);
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b1111;
        bus.req_len = {4{8'd2}};
        tag = "round_robin";
        for (int s = 0; s < 5; s++) begin
            push_service(s % 4, 2);
            push_idle();
        end
        check_cycles(4 * 4 + 3);
        @(negedge clk);
        bus.req = 4'b0000;
        check_cycles(1);

        tag = "drain";
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected entries left, expected 0", tag, sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
